// File: rtl/reg_dump_if.sv
// reg_dump_if: byte stream valid/ready channel from the dump engine to the transmitter
interface reg_dump_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output tx_data, tx_valid, input tx_ready);
    modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/reg_dump.sv
// reg_dump: stalls the core, reads every register through a spare port and streams it out as bytes
module reg_dump #(
    parameter int          bits = 16,
    parameter int          N    = 3,
    parameter logic [7:0]  HDR  = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            halt,
    input  logic            halted,
    output logic [N-1:0]    RA,
    input  logic [bits-1:0] RD,
    reg_dump_if.master      tx,
    output logic            busy,
    output logic            done
);
    localparam int CW = $clog2(bits / 8 + 1);
    typedef enum logic [2:0] {IDLE, HALT_WAIT, HEADER, LOAD, SEND, DONE} state_t;
    state_t          state, state_n;
    logic [N-1:0]    idx, idx_n;
    logic [bits-1:0] shift, shift_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            fire;
    assign fire = tx.tx_valid & tx.tx_ready;
    // next state, register index, byte shifter and byte count
    always_comb begin
        state_n = state;
        idx_n   = idx;
        shift_n = shift;
        cnt_n   = cnt;
        case (state)
            IDLE:      state_n = start ? HALT_WAIT : IDLE;
            HALT_WAIT: state_n = halted ? HEADER : HALT_WAIT;
            HEADER: if (fire) begin
                idx_n   = '0;
                state_n = LOAD;
            end
            LOAD: begin
                shift_n = RD;
                cnt_n   = CW'(bits / 8);
                state_n = SEND;
            end
            SEND: if (fire) begin
                shift_n = shift << 8;
                cnt_n   = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = &idx ? DONE : LOAD;
                    idx_n   = &idx ? idx : idx + N'(1);
                end
            end
            DONE: begin
                idx_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // state and outputs, all registered from the next-state values
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            shift       <= '0;
            cnt         <= '0;
            halt        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tx.tx_valid <= 1'b0;
            tx.tx_data  <= '0;
            RA          <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            shift       <= shift_n;
            cnt         <= cnt_n;
            halt        <= state_n inside {HALT_WAIT, HEADER, LOAD, SEND};
            busy        <= state_n != IDLE;
            done        <= state_n == DONE;
            tx.tx_valid <= state_n == HEADER || state_n == SEND;
            tx.tx_data  <= state_n == HEADER ? HDR : state_n == SEND ? shift_n[bits-1 -: 8] : tx.tx_data;
            RA          <= idx_n;
        end
    end
endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: scoreboard bench for the register dump byte stream
module tb_reg_dump;
    logic        clk = 0, rst = 1, start = 0, halted = 0;
    logic        halt, busy, done;
    logic [2:0]  RA;
    logic [15:0] RD;
    logic [15:0] regs [8];
    reg_dump_if tx();
    reg_dump #(.bits(16), .N(3), .HDR(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .halted(halted),
        .RA(RA), .RD(RD), .tx(tx), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    assign RD = regs[RA];
    int         checks = 0, failures = 0, nbytes = 0, done_cnt = 0, cyc = 0;
    logic [7:0] q [$];
    bit         rnd = 0, auto_halt = 1, man_halted = 0;
    logic       prev_stall = 0;
    logic [7:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_stream();
        q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            q.push_back(regs[i][15:8]);
            q.push_back(regs[i][7:0]);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_valid(output int c);
        int n = 0;
        @(negedge clk);
        while (!tx.tx_valid && n < 500) begin @(negedge clk); n++; end
        check("valid_seen", tx.tx_valid, 1);
        c = cyc;
    endtask

    task automatic wait_done(output int c);
        int n = 0;
        @(negedge clk);
        while (!done && n < 2000) begin @(negedge clk); n++; end
        check("done_seen", done, 1);
        c = cyc;
    endtask

    // input drivers: tx_ready and halted change just after each rising edge
    initial begin
        tx.tx_ready = 1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            tx.tx_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
            halted = auto_halt ? halt : man_halted;
        end
    end

    // monitor: scoreboard compare on each handshake, hold checks on stalls, done checks
    initial forever begin
        @(negedge clk);
        if (prev_stall) begin
            check("hold_valid", tx.tx_valid, 1);
            check("hold_data", tx.tx_data, prev_data);
        end
        if (tx.tx_valid && tx.tx_ready) begin
            nbytes++;
            if (q.size() == 0) check("byte_pending", 32'(q.size()), 1);
            else check("byte", tx.tx_data, q.pop_front());
        end
        if (done) begin
            done_cnt++;
            check("halt_in_done", halt, 0);
        end
        prev_stall = tx.tx_valid && !tx.tx_ready;
        prev_data  = tx.tx_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int h, d, n, dc;
        for (int i = 0; i < 8; i++) regs[i] = 16'h1111 * 16'(i + 1);
        @(negedge clk); @(negedge clk);
        check("rst_halt", halt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", tx.tx_valid, 0);
        check("rst_data", tx.tx_data, 0);
        check("rst_ra", RA, 0);
        @(posedge clk); #1 rst = 0;

        push_stream();
        pulse_start();
        wait_valid(h);
        wait_done(d);
        check("hdr_to_done", d - h, 25);
        @(negedge clk);
        check("q_empty_basic", q.size(), 0);
        check("done_count_1", done_cnt, 1);

        rnd = 1;
        push_stream();
        pulse_start();
        wait_done(d);
        rnd = 0;
        @(negedge clk);
        check("q_empty_random", q.size(), 0);
        check("done_count_2", done_cnt, 2);

        auto_halt = 0;
        man_halted = 0;
        push_stream();
        pulse_start();
        repeat (50) begin
            @(negedge clk);
            check("wait_halt", halt, 1);
            check("wait_busy", busy, 1);
            check("wait_valid", tx.tx_valid, 0);
        end
        man_halted = 1;
        @(posedge clk);
        @(negedge clk);
        check("hdr_not_yet", tx.tx_valid, 0);
        @(negedge clk);
        check("hdr_next_cycle", tx.tx_valid, 1);
        wait_done(d);
        auto_halt = 1;
        man_halted = 0;
        @(negedge clk);
        check("q_empty_halted", q.size(), 0);

        push_stream();
        pulse_start();
        n = 0;
        while (q.size() > 10 && n < 500) begin @(negedge clk); n++; end
        @(posedge clk); #1 start = 1;
        wait_done(d);
        push_stream();
        @(negedge clk);
        check("restart_idle_busy", busy, 0);
        check("restart_idle_halt", halt, 0);
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        check("restart_halt", halt, 1);
        check("restart_busy", busy, 1);
        wait_done(d);
        @(negedge clk);
        check("q_empty_restart", q.size(), 0);
        check("done_count_5", done_cnt, 5);

        nbytes = 0;
        push_stream();
        pulse_start();
        n = 0;
        while (nbytes < 9 && n < 500) begin @(negedge clk); #1; n++; end
        check("reach_r3_lo", nbytes, 9);
        check("r3_lo_data", tx.tx_data, 8'h44);
        rst = 1;
        q.delete();
        dc = done_cnt;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("mid_rst_halt", halt, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", tx.tx_valid, 0);
        check("mid_rst_data", tx.tx_data, 0);
        check("mid_rst_ra", RA, 0);
        @(negedge clk);
        check("mid_rst_no_done", done_cnt, dc);
        nbytes = 0;
        push_stream();
        pulse_start();
        wait_done(d);
        @(negedge clk);
        check("q_empty_after_rst", q.size(), 0);
        check("bytes_after_rst", nbytes, 17);

        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        regs[0] = 16'hFFFF;
        regs[7] = 16'h0001;
        nbytes = 0;
        push_stream();
        pulse_start();
        wait_done(d);
        repeat (5) @(negedge clk);
        check("q_empty_edge", q.size(), 0);
        check("bytes_edge", nbytes, 17);
        check("idle_ra", RA, 0);
        check("idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
